// File: rtl/mem_access.sv
// MEM-stage load/store unit: runs one req/ack data-bus transaction per memory op and stalls the pipeline meanwhile.
// Optional misaligned-access trapping is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            mem_aluop,
  input  logic [DATA_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_sdata,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic                  mem_we,
  output logic [DATA_W-1:0]     wb_wdata,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic                  wb_we,
  output logic                  stall_req,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_W-1:0]     bus_addr,
  output logic [3:0]            bus_sel,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  align_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic             is_mem, is_store, is_byte, is_half, is_word, is_signed;
  logic             misaligned, start;
  logic [1:0]       lane;
  logic [3:0]       sel_next;
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] byte_sh, half_sh;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] load_q;

  assign lane = mem_addr[1:0];

  always_comb begin
    is_mem    = (mem_aluop >= OP_LB) && (mem_aluop <= OP_SW);
    is_store  = (mem_aluop == OP_SB) || (mem_aluop == OP_SH) || (mem_aluop == OP_SW);
    is_byte   = (mem_aluop == OP_LB) || (mem_aluop == OP_LBU) || (mem_aluop == OP_SB);
    is_half   = (mem_aluop == OP_LH) || (mem_aluop == OP_LHU) || (mem_aluop == OP_SH);
    is_word   = (mem_aluop == OP_LW) || (mem_aluop == OP_SW);
    is_signed = (mem_aluop == OP_LB) || (mem_aluop == OP_LH);
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign start = is_mem && !misaligned;

  always_comb begin
    sel_next   = 4'b0000;
    wdata_next = mem_sdata;
    if (is_byte) begin
      sel_next   = 4'b0001 << lane;
      wdata_next = {4{mem_sdata[7:0]}};
    end else if (is_half) begin
      sel_next   = 4'b0011 << {lane[1], 1'b0};
      wdata_next = {2{mem_sdata[15:0]}};
    end else if (is_word) begin
      sel_next   = 4'b1111;
    end
  end

  // Lane extraction uses the still-stable EX/MEM address at ack time.
  assign byte_sh = bus_rdata >> {lane, 3'b000};
  assign half_sh = bus_rdata >> {lane[1], 4'b0000};

  always_comb begin
    load_ext = bus_rdata;
    if (is_byte)
      load_ext = {{(DATA_W-8){is_signed & byte_sh[7]}}, byte_sh[7:0]};
    else if (is_half)
      load_ext = {{(DATA_W-16){is_signed & half_sh[15]}}, half_sh[15:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    wb_we      = 1'b0;
    wb_wdata   = '0;
    wb_waddr   = mem_waddr;
    align_err  = 1'b0;
    if (rst) begin
      wb_waddr = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            stall_req  = 1'b1;
            state_next = BUSY;
          end else if (misaligned) begin
            align_err = 1'b1;
          end else begin
            wb_wdata = mem_wdata;
            wb_we    = mem_we;
          end
        end
        BUSY: begin
          stall_req = 1'b1;
          if (bus_ack) state_next = DONE;
        end
        DONE: begin
          wb_wdata   = load_q;
          wb_we      = mem_we;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      load_q    <= '0;
    end else begin
      if (state == IDLE && start) begin
        bus_req   <= 1'b1;
        bus_we    <= is_store;
        bus_addr  <= {mem_addr[DATA_W-1:2], 2'b00};
        bus_sel   <= sel_next;
        bus_wdata <= wdata_next;
      end else if (state == BUSY && bus_ack) begin
        bus_req <= 1'b0;
        if (!is_store) load_q <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_aluop;
  logic [31:0] mem_addr, mem_sdata, mem_wdata;
  logic [4:0]  mem_waddr;
  logic        mem_we;
  logic [31:0] wb_wdata;
  logic [4:0]  wb_waddr;
  logic        wb_we, stall_req, bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack, align_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .mem_aluop(mem_aluop), .mem_addr(mem_addr),
    .mem_sdata(mem_sdata), .mem_wdata(mem_wdata), .mem_waddr(mem_waddr),
    .mem_we(mem_we), .wb_wdata(wb_wdata), .wb_waddr(wb_waddr), .wb_we(wb_we),
    .stall_req(stall_req), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .align_err(align_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on op code, address and data.
  function automatic int unsigned size_of(input int op);
    if (op == 1 || op == 2 || op == 6) return 1;
    if (op == 3 || op == 4 || op == 7) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_sel(input int op, input logic [31:0] a);
    int unsigned sz = size_of(op);
    int unsigned lo = a % 4;
    if (sz == 1) return 32'(1 << lo);
    if (sz == 2) return 32'(3 << (2 * (lo / 2)));
    return 32'd15;
  endfunction

  function automatic logic [31:0] exp_bwdata(input int op, input logic [31:0] d);
    if (op == 6) return (d % 256) * 32'h01010101;
    if (op == 7) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input int op, input logic [31:0] a, input logic [31:0] r);
    int unsigned lo = a % 4;
    logic [31:0] v;
    if (size_of(op) == 1) begin
      v = (r >> (8 * lo)) % 256;
      if (op == 1 && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size_of(op) == 2) begin
      v = (r >> (16 * (lo / 2))) % 65536;
      if (op == 3 && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  task automatic run_mem(input int op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] wa, input logic we, input logic [31:0] rd,
                         input int waits);
    int stalls = 0;
    mem_aluop = 4'(op); mem_addr = a; mem_sdata = sd; mem_waddr = wa; mem_we = we;
    mem_wdata = $urandom; bus_ack = 1'b0;
    #1;
    chk("idle_stall", 32'(stall_req), 1);
    chk("idle_wb_we", 32'(wb_we), 0);
    stalls += int'(stall_req);
    step();
    chk("busy_req", 32'(bus_req), 1);
    chk("busy_we", 32'(bus_we), (op >= 6) ? 1 : 0);
    chk("busy_addr", bus_addr, a - (a % 4));
    chk("busy_sel", 32'(bus_sel), exp_sel(op, a));
    if (op >= 6) chk("busy_wdata", bus_wdata, exp_bwdata(op, sd));
    for (int i = 0; i < waits; i++) begin
      stalls += int'(stall_req);
      chk("hold_req", 32'(bus_req), 1);
      step();
    end
    bus_rdata = rd; bus_ack = 1'b1;
    #1;
    stalls += int'(stall_req);
    step();
    bus_ack = 1'b0; bus_rdata = $urandom;
    #1;
    chk("done_stall", 32'(stall_req), 0);
    chk("done_req", 32'(bus_req), 0);
    chk("done_wb_we", 32'(wb_we), 32'(we));
    chk("done_waddr", 32'(wb_waddr), 32'(wa));
    if (op <= 5) chk("done_wdata", wb_wdata, exp_load(op, a, rd));
    chk("stall_cycles", stalls, waits + 2);
    step();
  endtask

  task automatic run_alu(input int op, input logic [31:0] wd, input logic [4:0] wa, input logic we);
    mem_aluop = 4'(op); mem_wdata = wd; mem_waddr = wa; mem_we = we;
    mem_addr = $urandom; bus_ack = 1'b0;
    #1;
    chk("alu_wdata", wb_wdata, wd);
    chk("alu_waddr", 32'(wb_waddr), 32'(wa));
    chk("alu_we", 32'(wb_we), 32'(we));
    chk("alu_stall", 32'(stall_req), 0);
    step();
    chk("alu_no_req", 32'(bus_req), 0);
  endtask

  initial begin
    int op;
    logic [31:0] a;
    rst = 1'b1; mem_aluop = 4'd5; mem_addr = 32'h100; mem_sdata = 0;
    mem_wdata = 32'hCAFEF00D; mem_waddr = 5'd7; mem_we = 1'b1;
    bus_rdata = 0; bus_ack = 1'b0;
    step();
    step();
    chk("rst_stall", 32'(stall_req), 0);
    chk("rst_wb_we", 32'(wb_we), 0);
    chk("rst_wdata", wb_wdata, 0);
    chk("rst_waddr", 32'(wb_waddr), 0);
    chk("rst_align", 32'(align_err), 0);
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_bus_sel", 32'(bus_sel), 0);
    chk("rst_bus_addr", bus_addr, 0);
    rst = 1'b0; mem_aluop = 4'd0;

    run_alu(0, 32'h12345678, 5'd3, 1'b1);
    run_alu(12, 32'h0BADBEEF, 5'd9, 1'b0);

    run_mem(1, 32'h1003, 0, 5'd4, 1'b1, 32'h80FF0102, 0);
    run_mem(2, 32'h1003, 0, 5'd4, 1'b1, 32'h80FF0102, 0);
    run_mem(7, 32'h2002, 32'hAAAA1234, 5'd0, 1'b0, 0, 3);

    // Reset asserted for one cycle mid-transaction, then a stray ack.
    mem_aluop = 4'd5; mem_addr = 32'h40; mem_we = 1'b1; mem_waddr = 5'd2;
    step();
    chk("mid_busy_req", 32'(bus_req), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall_req), 0);
    chk("mid_rst_wb_we", 32'(wb_we), 0);
    step();
    rst = 1'b0; mem_aluop = 4'd0; mem_we = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
    #1;
    chk("post_rst_req", 32'(bus_req), 0);
    chk("stray_ack_wb_we", 32'(wb_we), 0);
    chk("stray_ack_stall", 32'(stall_req), 0);
    step();
    bus_ack = 1'b0;
    chk("stray_ack_no_req", 32'(bus_req), 0);

    run_mem(5, 32'h500, 0, 5'd10, 1'b1, 32'hDEADBEEF, 1);
    run_mem(8, 32'h504, 32'h01020304, 5'd0, 1'b0, 0, 0);

`ifdef MEM_ALIGN_CHECK_EN
    mem_aluop = 4'd5; mem_addr = 32'h3001; mem_we = 1'b1;
    #1;
    chk("align_err", 32'(align_err), 1);
    chk("align_wb_we", 32'(wb_we), 0);
    chk("align_stall", 32'(stall_req), 0);
    step();
    chk("align_no_req", 32'(bus_req), 0);
    mem_aluop = 4'd0;
`else
    run_mem(5, 32'h3001, 0, 5'd11, 1'b1, 32'h13579BDF, 0);
    chk("noalign_err", 32'(align_err), 0);
`endif

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 15));
      a  = $urandom;
      if (op >= 1 && op <= 8) begin
`ifdef MEM_ALIGN_CHECK_EN
        if (size_of(op) == 2) a[0] = 1'b0;
        if (size_of(op) == 4) a[1:0] = 2'b00;
`endif
        run_mem(op, a, $urandom, 5'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)));
      end else begin
        run_alu(op, $urandom, 5'($urandom), 1'($urandom));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage load/store unit of the 5-stage pipeline.
- Consumes the EX/MEM pipeline register outputs and runs a req/ack transaction on the data bus. Drives sign/zero-extended load results toward the MEM/WB register.
- Holds the pipeline via stall_req while a bus transaction is outstanding.
- Non-memory instructions pass straight through.

Parameters:
- DATA_W, 32, data and address width. Fixed at 32 for byte-lane logic.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_aluop  in  4  memory op from EX/MEM: 0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NOP
- mem_addr  in  32  effective byte address
- mem_sdata  in  32  store data, rt value
- mem_wdata  in  32  ALU result for non-load ops
- mem_waddr  in  REG_ADDR_W  destination register
- mem_we  in  1  register write enable
- wb_wdata  out  32  result toward MEM/WB
- wb_waddr  out  REG_ADDR_W  destination toward MEM/WB
- wb_we  out  1  write enable toward MEM/WB
- stall_req  out  1  pipeline hold request
- bus_req  out  1  transaction request, registered
- bus_we  out  1  1 = store, registered
- bus_addr  out  32  word-aligned address: addr[31:2], low bits 00; registered
- bus_sel  out  4  byte-lane enables, little-endian, registered
- bus_wdata  out  32  lane-replicated store data, registered
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  single-cycle completion strobe
- align_err  out  1  misaligned-access flag; see Optional Feature

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE, mem op present (ops 1-8):
  - stall_req=1 combinationally.
  - Next edge: load bus_addr, bus_we, bus_sel, bus_wdata; set bus_req=1; go to BUSY.
- BUSY:
  - stall_req=1. bus_req and all bus outputs held stable until bus_ack.
  - On bus_ack: register the extended load result (stores: none), drop bus_req at the same edge, go to DONE.
- DONE:
  - stall_req=0.
  - wb_wdata = captured load result; wb_waddr = mem_waddr; wb_we = mem_we.
  - Next edge: go to IDLE unconditionally. The next instruction is evaluated in IDLE.
- EX/MEM inputs are held stable by the stall controller while stall_req=1. The block does not re-latch them.
- While stall_req=1, wb_we=0; wb_wdata/wb_waddr are don't-care but driven deterministically.
- IDLE, non-mem op:
  - wb_wdata=mem_wdata, wb_waddr=mem_waddr, wb_we=mem_we, combinationally.
  - No stall, no bus activity.
- Byte lane select, where a = addr[1:0]:
  - Byte ops: bus_sel = 0001 << a.
  - Half ops: bus_sel = 0011 << (2*a[1]).
  - Word ops: bus_sel = 1111.
- Store data replication:
  - SB: sdata[7:0] replicated to all four lanes.
  - SH: sdata[15:0] replicated to both halves.
  - SW: sdata unchanged.
- Load extraction: select the lane by addr, then extend.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: full word.
- Stores: wb_we follows mem_we in DONE (normally 0).
- Latency:
  - Non-mem ops: 0 extra cycles.
  - Mem op with ack on the first BUSY cycle: 2 stall cycles; result in the 3rd cycle.
  - Each extra wait cycle adds one stall cycle.
- bus_ack in IDLE or DONE is ignored.
- Reset mid-transaction: next edge forces IDLE, bus_req=0, stall_req follows the IDLE rule. A late ack is ignored.
- Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0, captured result=0.
- While rst is high, combinational outputs are forced: wb_we=0, wb_wdata=0, wb_waddr=0, stall_req=0, align_err=0.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A misaligned access is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Misaligned accesses are treated as NOP for the bus: no transaction, no stall.
  - wb_we=0 and align_err=1, combinationally, for that IDLE cycle.
- Undefined:
  - align_err tied 0.
  - Low address bits are ignored: half ops use addr[1], word ops ignore addr[1:0]. The access proceeds as aligned.

Test Plan:
- ALU op passes through: aluop=0, wdata=0x12345678, waddr=3, we=1 → same cycle wb_wdata=0x12345678, wb_waddr=3, wb_we=1, stall_req=0, bus_req stays 0.
- LB, ack after 1 cycle: addr=0x1003, rdata=0x80FF0102 → bus_addr=0x1000, bus_sel=1000, stall 2 cycles, then wb_wdata=0xFFFFFF80, wb_we=1; LBU from the same data gives 0x00000080.
- SH with wait states: addr=0x2002, sdata=0xAAAA1234, ack after 4 BUSY cycles → bus_we=1, bus_sel=1100, bus_wdata=0x12341234, bus_req held 4 cycles, stall_req=1 for 5 cycles, then 0.
- Reset mid-BUSY: assert rst for 1 cycle during LW, then drive ack → bus_req=0 after the edge, state IDLE, stray ack produces no wb_we.
- Back-to-back LW then SW: two complete transactions; DONE of the first lasts exactly 1 cycle before the second's IDLE stall; LW rdata=0xDEADBEEF appears on wb_wdata.
- With MEM_ALIGN_CHECK_EN: LW addr=0x3001 → align_err=1, wb_we=0, stall_req=0, no bus_req. Without the macro: bus_addr=0x3000, bus_sel=1111, normal load.
